// File: rtl/inspeccion_pkg.sv
// Shared definitions for the inspection/protocol path: Y codes, E status codes,
// responder FSM states and a saturating counter helper.
package inspeccion_pkg;

  localparam logic [1:0] Y_NONE   = 2'b00;
  localparam logic [1:0] Y_PASS   = 2'b01;
  localparam logic [1:0] Y_DIVERT = 2'b10;
  localparam logic [1:0] Y_ALARM  = 2'b11;

  // Status codes produced by the inspection stage upstream of the protocol.
  typedef enum logic [1:0] {
    E_NONE   = 2'b00,
    E_OK     = 2'b01,
    E_DEFECT = 2'b10,
    E_FAULT  = 2'b11
  } e_code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PULSE  = 2'b01,
    SETTLE = 2'b10
  } fsm_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cola_cmd.sv
// Synchronous command FIFO; a push into a full queue is accepted only when a
// pop frees a slot on the same edge, otherwise it is dropped and flagged.
module cola_cmd #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !pop;
  assign dout    = mem[rd_ptr];

  // NOTE: storage carries no reset; only the pointers and count define
  // validity, so resetting the array would add reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/clasificador_actuador.sv
// Responder end of the protocol path: edge-detects Y commands, queues pass and
// divert, and drives one timed gate pulse per command; alarm stops the line.
module clasificador_actuador
  import inspeccion_pkg::*;
#(
  parameter int PULSE_LEN  = 4,
  parameter int SETTLE_LEN = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] y_cmd,
  input  logic       clr,
  output logic       gate_pass,
  output logic       gate_divert,
  output logic       alarm,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] cnt_pass,
  output logic [7:0] cnt_div
);

  logic [1:0] y_prev;
  logic       cmd_new;
  logic       push;
  logic       alarm_cmd;
  logic       pop;
  logic       empty;
  logic       drop;
  logic [1:0] head;
  logic       done;
  logic       pop_pass;
  logic       pop_div;
  logic [3:0] timer;
  fsm_state_t state;

  assign cmd_new   = (y_cmd != Y_NONE) && (y_prev == Y_NONE);
  assign push      = cmd_new && ((y_cmd == Y_PASS) || (y_cmd == Y_DIVERT));
  assign alarm_cmd = cmd_new && (y_cmd == Y_ALARM);

  // The edge that would return the FSM to IDLE may pop directly, so queued
  // commands run back-to-back with exactly PULSE_LEN + SETTLE_LEN spacing.
  assign done = ((state == PULSE) && (timer == 4'd0) && (SETTLE_LEN == 0)) ||
                ((state == SETTLE) && (timer == 4'd0));
  assign pop      = !empty && !alarm && ((state == IDLE) || done);
  assign pop_pass = pop && (head == Y_PASS);
  assign pop_div  = pop && (head == Y_DIVERT);
  assign busy     = (state != IDLE);

  cola_cmd #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_cola (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (y_cmd),
    .dout  (head),
    .empty (empty),
    .full  (fifo_full),
    .drop  (drop)
  );

  // NOTE: every register below uses <= so all updates see pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_prev <= Y_NONE;
    else        y_prev <= y_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= 4'd0;
      gate_pass   <= 1'b0;
      gate_divert <= 1'b0;
    end else if (pop) begin
      state       <= PULSE;
      timer       <= 4'(PULSE_LEN - 1);
      gate_pass   <= (head == Y_PASS);
      gate_divert <= (head == Y_DIVERT);
    end else begin
      case (state)
        PULSE: begin
          if (timer == 4'd0) begin
            gate_pass   <= 1'b0;
            gate_divert <= 1'b0;
            state       <= (SETTLE_LEN == 0) ? IDLE : SETTLE;
            timer       <= 4'(SETTLE_LEN - 1);
          end else begin
            timer <= timer - 4'd1;
          end
        end
        SETTLE: begin
          if (timer == 4'd0) state <= IDLE;
          else               timer <= timer - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new alarm or dropped command outranks a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm    <= 1'b0;
      overflow <= 1'b0;
      cnt_pass <= 8'd0;
      cnt_div  <= 8'd0;
    end else begin
      if (alarm_cmd) alarm <= 1'b1;
      else if (clr)  alarm <= 1'b0;

      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;

      if (clr)           cnt_pass <= {7'd0, pop_pass};
      else if (pop_pass) cnt_pass <= sat_inc8(cnt_pass);

      if (clr)          cnt_div <= {7'd0, pop_div};
      else if (pop_div) cnt_div <= sat_inc8(cnt_div);
    end
  end

endmodule

// File: tb/tb_clasificador_actuador.sv
// Self-checking bench: directed scenarios plus random codes, all compared every
// cycle against a queue/schedule model of the command path.
module tb_clasificador_actuador;
  import inspeccion_pkg::*;

  localparam int P = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] y_cmd = 2'b00;
  logic       clr = 1'b0;
  logic       gate_pass, gate_divert, alarm, busy, fifo_full, overflow;
  logic [7:0] cnt_pass, cnt_div;

  always #5 clk = ~clk;

  clasificador_actuador #(
    .PULSE_LEN  (P),
    .SETTLE_LEN (S),
    .FIFO_DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .y_cmd       (y_cmd),
    .clr         (clr),
    .gate_pass   (gate_pass),
    .gate_divert (gate_divert),
    .alarm       (alarm),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .cnt_pass    (cnt_pass),
    .cnt_div     (cnt_div)
  );

  int checks   = 0;
  int failures = 0;

  // Model: command queue plus the schedule of the most recent pop.
  int         n;
  logic [1:0] m_yprev;
  logic [1:0] q[$];
  int         next_free;
  bit         any_pop;
  int         last_start;
  logic [1:0] last_typ;
  bit         m_alarm, m_ov;
  int         m_cp, m_cd;

  // Observations of DUT activity per scenario.
  int gp_rise, gd_rise, gp_high, gd_high, busy_high;
  bit gp_last, gd_last, full_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_yprev = 2'b00; q.delete(); next_free = 0; any_pop = 0;
    last_start = 0; last_typ = 2'b00; m_alarm = 0; m_ov = 0; m_cp = 0; m_cd = 0;
  endtask

  task automatic clear_obs();
    gp_rise = 0; gd_rise = 0; gp_high = 0; gd_high = 0; busy_high = 0;
    gp_last = 0; gd_last = 0; full_seen = 0;
  endtask

  task automatic model_edge(input logic [1:0] y, input bit c);
    bit cmd, pop, drop;
    logic [1:0] typ;
    cmd = (y != 2'b00) && (m_yprev == 2'b00);
    m_yprev = y;
    pop = (q.size() > 0) && !m_alarm && (n >= next_free);
    typ = 2'b00;
    drop = 0;
    if (pop) begin
      typ = q.pop_front();
      last_start = n; last_typ = typ; next_free = n + P + S; any_pop = 1;
    end
    if (cmd && (y == Y_PASS || y == Y_DIVERT)) begin
      if (q.size() < D) q.push_back(y);
      else drop = 1;
    end
    if (c) begin
      m_cp = (pop && typ == Y_PASS)   ? 1 : 0;
      m_cd = (pop && typ == Y_DIVERT) ? 1 : 0;
    end else begin
      if (pop && typ == Y_PASS   && m_cp < 255) m_cp++;
      if (pop && typ == Y_DIVERT && m_cd < 255) m_cd++;
    end
    if (cmd && y == Y_ALARM) m_alarm = 1;
    else if (c)              m_alarm = 0;
    if (drop)   m_ov = 1;
    else if (c) m_ov = 0;
  endtask

  task automatic compare_all();
    bit in_pulse;
    in_pulse = any_pop && ((n - last_start) < P);
    check("gate_pass",   gate_pass,   in_pulse && last_typ == Y_PASS);
    check("gate_divert", gate_divert, in_pulse && last_typ == Y_DIVERT);
    check("busy",        busy,        any_pop && (n < last_start + P + S));
    check("fifo_full",   fifo_full,   q.size() == D);
    check("overflow",    overflow,    m_ov);
    check("alarm",       alarm,       m_alarm);
    check("cnt_pass",    cnt_pass,    m_cp);
    check("cnt_div",     cnt_div,     m_cd);
  endtask

  task automatic cycle(input logic [1:0] y, input bit c);
    y_cmd = y;
    clr   = c;
    @(posedge clk);
    model_edge(y, c);
    #1;
    compare_all();
    n++;
    if (gate_pass && !gp_last)   gp_rise++;
    if (gate_divert && !gd_last) gd_rise++;
    gp_last = gate_pass;
    gd_last = gate_divert;
    gp_high += int'(gate_pass);
    gd_high += int'(gate_divert);
    busy_high += int'(busy);
    if (fifo_full) full_seen = 1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(2'b00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gate_pass"}, gate_pass, 1'b0);
    check({tag, "_gate_divert"}, gate_divert, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_fifo_full"}, fifo_full, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_alarm"}, alarm, 1'b0);
    check({tag, "_cnt_pass"}, cnt_pass, 8'd0);
    check({tag, "_cnt_div"}, cnt_div, 8'd0);
  endtask

  initial begin
    logic [1:0] ry;
    int hold;

    // Reset state.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Single held pass command yields one 4-cycle pulse and 6 busy cycles.
    clear_obs();
    for (int i = 0; i < 6; i++) cycle(2'b01, 1'b0);
    idle(10);
    check("held_pass_rises", gp_rise, 1);
    check("held_pass_high", gp_high, P);
    check("held_busy_cycles", busy_high, P + S);
    check("held_cnt_pass", cnt_pass, 8'd1);

    // Pass / divert / pass back-to-back.
    cycle(2'b00, 1'b1);
    clear_obs();
    cycle(2'b01, 1'b0); cycle(2'b00, 1'b0);
    cycle(2'b10, 1'b0); cycle(2'b00, 1'b0);
    cycle(2'b01, 1'b0); cycle(2'b00, 1'b0);
    idle(20);
    check("seq_pass_rises", gp_rise, 2);
    check("seq_div_rises", gd_rise, 1);
    check("seq_cnt_pass", cnt_pass, 8'd2);
    check("seq_cnt_div", cnt_div, 8'd1);

    // Overflow: divert in flight, then six passes on alternate cycles.
    cycle(2'b00, 1'b1);
    clear_obs();
    cycle(2'b10, 1'b0); cycle(2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(2'b01, 1'b0);
      cycle(2'b00, 1'b0);
    end
    idle(40);
    check("ovf_full_seen", full_seen, 1'b1);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_pass_pulses", gp_rise, 5);

    // Alarm during the 2nd divert cycle; queued pass waits for clr.
    cycle(2'b00, 1'b1);
    clear_obs();
    cycle(2'b10, 1'b0); cycle(2'b00, 1'b0); cycle(2'b00, 1'b0);
    cycle(2'b11, 1'b0);
    check("alarm_immediate", alarm, 1'b1);
    cycle(2'b00, 1'b0); cycle(2'b01, 1'b0);
    idle(20);
    check("alarm_div_high", gd_high, P);
    check("alarm_pass_held", gp_rise, 0);
    check("alarm_still_set", alarm, 1'b1);
    cycle(2'b00, 1'b1);
    idle(15);
    check("alarm_pass_after_clr", gp_rise, 1);
    check("alarm_cnt_div_cleared", cnt_div, 8'd0);
    check("alarm_cnt_pass_after", cnt_pass, 8'd1);

    // Counter saturation after 257 pass pulses.
    cycle(2'b00, 1'b1);
    for (int i = 0; i < 257; i++) begin
      cycle(2'b01, 1'b0);
      idle(5);
    end
    idle(10);
    check("sat_cnt_pass", cnt_pass, 8'd255);

    // Asynchronous reset mid-pulse with two commands queued.
    clear_obs();
    cycle(2'b01, 1'b0); cycle(2'b00, 1'b0);
    cycle(2'b01, 1'b0); cycle(2'b00, 1'b0);
    cycle(2'b01, 1'b0);
    check("rst_mid_gate_high", gate_pass, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    y_cmd = 2'b00;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    clear_obs();
    idle(20);
    check("rst_no_pulses_after", gp_rise + gd_rise, 0);

    // Random codes with random hold lengths and occasional clears.
    for (int i = 0; i < 150; i++) begin
      ry   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if (ry == Y_ALARM && $urandom_range(0, 3) != 0) ry = Y_PASS;
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) cycle(ry, $urandom_range(0, 24) == 0);
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
